// File: rtl/baudot_ascii_bridge.sv
// baudot_ascii_bridge
//   Single-clock Baudot (ITA2 / US-TTY) serial receiver with LTRS/FIGS shift
//   decoding, an ASCII FIFO and an 8N1 ASCII serial transmitter. Both bit
//   rates are integer divisions of clk; the FIFO absorbs the rate mismatch.
//
//   Optional feature: define BAUDOT_USOS_EN to enable unshift-on-space
//   (code 0x04 emits 0x20 and then forces letters mode).
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   baudot_rx     Baudot serial line, idle high, asynchronous to clk
//   ascii_tx      ASCII 8N1 serial out, LSB first, idle high
//   baudot_valid  one-cycle pulse on a good Baudot frame
//   baudot_code   last good 5-bit code, held until the next good frame
//   figs_mode     shift state: 0 = letters, 1 = figures
//   frame_err     one-cycle pulse when the stop bit is sampled low
//   fifo_overflow sticky: a character was dropped because the FIFO was full
//   tx_busy       high while an ASCII frame is on ascii_tx
module baudot_ascii_bridge #(
  parameter int BAUDOT_DIV = 211,
  parameter int ASCII_DIV  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baudot_rx,
  output logic       ascii_tx,
  output logic       baudot_valid,
  output logic [4:0] baudot_code,
  output logic       figs_mode,
  output logic       frame_err,
  output logic       fifo_overflow,
  output logic       tx_busy
);

  localparam int BCW = $clog2(BAUDOT_DIV);
  localparam int ACW = (ASCII_DIV > 1) ? $clog2(ASCII_DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [BCW-1:0] HALF_M1 = BCW'(BAUDOT_DIV / 2 - 1);
  localparam logic [BCW-1:0] BIT_M1  = BCW'(BAUDOT_DIV - 1);
  localparam logic [ACW-1:0] ABIT_M1 = ACW'(ASCII_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // ---------------- synchroniser + receiver ----------------
  logic [1:0]     rx_sync;
  logic           rx_s, rx_prev;
  rx_state_t      rx_state;
  logic [BCW-1:0] rx_cnt;
  logic [2:0]     rx_bit;
  logic [4:0]     rx_shift;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= '1;
    else        rx_sync <= {rx_sync[0], baudot_rx};
  end

  // rx_prev tracks the line in every state, so after a framing error (line
  // still low) no falling edge is seen until the line has been high again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rx_prev      <= 1'b1;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      baudot_code  <= '0;
      baudot_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_prev      <= rx_s;
      baudot_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + BCW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_M1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[4:1]};
            if (rx_bit == 3'd4) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + BCW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_M1) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s) begin
              baudot_code  <= rx_shift;
              baudot_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + BCW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- shift decode / translate ----------------
  function automatic logic [6:0] xlate(input logic [4:0] c, input logic f);
    logic [6:0] l, g;
    l = 7'h00;
    g = 7'h00;
    case (c)
      5'h01: begin l = 7'h45; g = 7'h33; end
      5'h02: begin l = 7'h0A; g = 7'h0A; end
      5'h03: begin l = 7'h41; g = 7'h2D; end
      5'h04: begin l = 7'h20; g = 7'h20; end
      5'h05: begin l = 7'h53; g = 7'h07; end
      5'h06: begin l = 7'h49; g = 7'h38; end
      5'h07: begin l = 7'h55; g = 7'h37; end
      5'h08: begin l = 7'h0D; g = 7'h0D; end
      5'h09: begin l = 7'h44; g = 7'h24; end
      5'h0A: begin l = 7'h52; g = 7'h34; end
      5'h0B: begin l = 7'h4A; g = 7'h27; end
      5'h0C: begin l = 7'h4E; g = 7'h2C; end
      5'h0D: begin l = 7'h46; g = 7'h21; end
      5'h0E: begin l = 7'h43; g = 7'h3A; end
      5'h0F: begin l = 7'h4B; g = 7'h28; end
      5'h10: begin l = 7'h54; g = 7'h35; end
      5'h11: begin l = 7'h5A; g = 7'h22; end
      5'h12: begin l = 7'h4C; g = 7'h29; end
      5'h13: begin l = 7'h57; g = 7'h32; end
      5'h14: begin l = 7'h48; g = 7'h23; end
      5'h15: begin l = 7'h59; g = 7'h36; end
      5'h16: begin l = 7'h50; g = 7'h30; end
      5'h17: begin l = 7'h51; g = 7'h31; end
      5'h18: begin l = 7'h4F; g = 7'h39; end
      5'h19: begin l = 7'h42; g = 7'h3F; end
      5'h1A: begin l = 7'h47; g = 7'h26; end
      5'h1C: begin l = 7'h4D; g = 7'h2E; end
      5'h1D: begin l = 7'h58; g = 7'h2F; end
      5'h1E: begin l = 7'h56; g = 7'h3B; end
      default: begin l = 7'h00; g = 7'h00; end
    endcase
    return f ? g : l;
  endfunction

  logic       tr_valid;
  logic [7:0] tr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      figs_mode <= 1'b0;
      tr_valid  <= 1'b0;
      tr_data   <= '0;
    end else begin
      tr_valid <= 1'b0;
      if (baudot_valid) begin
        case (baudot_code)
          5'h1F: figs_mode <= 1'b0;
          5'h1B: figs_mode <= 1'b1;
          5'h00: ;
          default: begin
            tr_valid <= 1'b1;
            tr_data  <= {1'b0, xlate(baudot_code, figs_mode)};
`ifdef BAUDOT_USOS_EN
            if (baudot_code == 5'h04) figs_mode <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

  // ---------------- ASCII FIFO ----------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, wr_en;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  // When full, a push is still accepted if the transmitter pops in the same cycle.
  assign wr_en = tr_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= tr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      if (tr_valid && !wr_en) fifo_overflow <= 1'b1;
    end
  end

  // ---------------- ASCII transmitter ----------------
  tx_state_t      tx_state;
  logic [ACW-1:0] tx_cnt;
  logic [3:0]     tx_bit;
  logic [8:0]     tx_shift;
  logic           frame_end;

  // Popping on the last cycle of the stop bit lets the next start bit follow
  // with no idle gap.
  always_comb begin
    frame_end = (tx_state == TX_SEND) && (tx_cnt == ABIT_M1) && (tx_bit == 4'd9);
    pop       = !empty && ((tx_state == TX_IDLE) || frame_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      ascii_tx <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else if (pop) begin
      tx_state <= TX_SEND;
      ascii_tx <= 1'b0;
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, mem[rd_ptr]};
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else if (tx_state == TX_SEND) begin
      if (tx_cnt == ABIT_M1) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_state <= TX_IDLE;
          tx_busy  <= 1'b0;
        end else begin
          ascii_tx <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[8:1]};
          tx_bit   <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + ACW'(1);
      end
    end
  end

endmodule

// File: tb/tb_baudot_ascii_bridge.sv
module tb_baudot_ascii_bridge;

  localparam int BDIV = 16;
  localparam int ADIV = 4;
  localparam int ODIV = 256;

`ifdef BAUDOT_USOS_EN
  localparam bit USOS = 1'b1;
`else
  localparam bit USOS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_m = 1'b1, rx_o = 1'b1;
  logic tx_m, valid_m, figs_m, err_m, ovf_m, busy_m;
  logic tx_o, valid_o, figs_o, err_o, ovf_o, busy_o;
  logic [4:0] code_m, code_o;

  always #5 clk = ~clk;

  baudot_ascii_bridge #(.BAUDOT_DIV(BDIV), .ASCII_DIV(ADIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .baudot_rx(rx_m), .ascii_tx(tx_m),
    .baudot_valid(valid_m), .baudot_code(code_m), .figs_mode(figs_m),
    .frame_err(err_m), .fifo_overflow(ovf_m), .tx_busy(busy_m));

  baudot_ascii_bridge #(.BAUDOT_DIV(BDIV), .ASCII_DIV(ODIV), .FIFO_DEPTH(4)) dut_ovf (
    .clk(clk), .rst_n(rst_n), .baudot_rx(rx_o), .ascii_tx(tx_o),
    .baudot_valid(valid_o), .baudot_code(code_o), .figs_mode(figs_o),
    .frame_err(err_o), .fifo_overflow(ovf_o), .tx_busy(busy_o));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt [2] = '{0, 0};
  int ecnt [2] = '{0, 0};
  int last_vcyc [2] = '{0, 0};
  int last_start [2] = '{0, 0};
  int mfigs [2] = '{0, 0};
  logic [4:0] last_code [2] = '{5'h00, 5'h00};
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  // ITA2 tables; '~' marks entries handled specially by model_char.
  string ltr_s = "~E~A SIU~DRJNFCKTZLWHYPQOBG~MXV~";
  string fig_s = "~3~- ~87~$4',!:(5~)2#6019?&~./;~";

  typedef struct {
    logic [4:0] code;
    bit         stop_ok;
    bit         has;
    logic [7:0] ch;
    bit         figs;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_tx(input int w);   return (w != 0) ? tx_o : tx_m;     endfunction
  function automatic logic get_busy(input int w); return (w != 0) ? busy_o : busy_m; endfunction
  function automatic logic [4:0] get_code(input int w); return (w != 0) ? code_o : code_m; endfunction
  function automatic logic get_figs(input int w); return (w != 0) ? figs_o : figs_m; endfunction

  always @(posedge clk) cyc++;

  // Pulse counters for both instances.
  initial forever begin
    @(posedge clk); #1;
    if (valid_m === 1'b1) begin vcnt[0]++; last_vcyc[0] = cyc; end
    if (err_m === 1'b1) ecnt[0]++;
    if (valid_o === 1'b1) begin vcnt[1]++; last_vcyc[1] = cyc; end
    if (err_o === 1'b1) ecnt[1]++;
  end

  // ASCII line decoder: samples every cycle of a frame, checks bit widths,
  // start/stop levels, tx_busy, and the byte against the expected queue.
  task automatic uart_mon(input int w, input int div);
    logic [7:0] d;
    logic cur;
    bit shape_ok, busy_ok, have;
    have = 1'b0;
    forever begin
      if (!have) begin @(posedge clk); #1; end
      have = 1'b0;
      if (get_tx(w) === 1'b0) begin
        last_start[w] = cyc;
        shape_ok = 1'b1; busy_ok = 1'b1; d = '0; cur = 1'b0;
        for (int k = 0; k < 10 * div; k++) begin
          if (k > 0) begin @(posedge clk); #1; end
          if (k % div == 0) cur = get_tx(w);
          else if (get_tx(w) !== cur) shape_ok = 1'b0;
          if (get_busy(w) !== 1'b1) busy_ok = 1'b0;
          if (k % div == 0 && k / div >= 1 && k / div <= 8) d[k / div - 1] = cur;
          if (k % div == 0 && k / div == 9 && cur !== 1'b1) shape_ok = 1'b0;
        end
        check("tx_frame_shape", shape_ok, 1);
        check("tx_busy_in_frame", busy_ok, 1);
        if ((w == 0 && q0.size() == 0) || (w != 0 && q1.size() == 0)) begin
          checks++; errors++;
          $display("FAIL tx_unexpected dut=%0d actual=%0h required=no_frame", w, d);
        end else if (w == 0) check("tx_byte_main", d, q0.pop_front());
        else check("tx_byte_ovf", d, q1.pop_front());
        @(posedge clk); #1;
        if (get_tx(w) === 1'b0) have = 1'b1;
        else check("tx_busy_after_frame", get_busy(w), 0);
      end
    end
  endtask

  initial uart_mon(0, ADIV);
  initial uart_mon(1, ODIV);

  task automatic set_rx(input int w, input logic v);
    if (w != 0) rx_o = v; else rx_m = v;
  endtask

  task automatic send_frame(input int w, input logic [4:0] c, input bit stop_ok, input int gap);
    set_rx(w, 1'b0);
    repeat (BDIV) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      set_rx(w, c[i]);
      repeat (BDIV) @(negedge clk);
    end
    set_rx(w, stop_ok);
    repeat (BDIV) @(negedge clk);
    set_rx(w, 1'b1);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_frame(input int w, input logic [4:0] c, input bit stop_ok, input int gap,
                          input bit has, input logic [7:0] ch, input bit figs);
    int v0, e0;
    v0 = vcnt[w];
    e0 = ecnt[w];
    if (has) begin
      if (w != 0) q1.push_back(ch); else q0.push_back(ch);
    end
    send_frame(w, c, stop_ok, gap);
    if (stop_ok) begin
      check("valid_pulse", vcnt[w] - v0, 1);
      check("no_frame_err", ecnt[w] - e0, 0);
      check("baudot_code", get_code(w), c);
      last_code[w] = c;
    end else begin
      check("frame_err_pulse", ecnt[w] - e0, 1);
      check("no_valid_on_err", vcnt[w] - v0, 0);
      check("code_held", get_code(w), last_code[w]);
    end
    check("figs_mode", get_figs(w), figs);
  endtask

  function automatic logic [7:0] model_char(input logic [4:0] c, input int f);
    if (c == 5'h02) return 8'h0A;
    if (c == 5'h08) return 8'h0D;
    if (f != 0 && c == 5'h05) return 8'h07;
    if (f != 0 && c == 5'h11) return 8'h22;
    return (f != 0) ? fig_s[c] : ltr_s[c];
  endfunction

  // Shift-state model applied to a good frame.
  task automatic model_step(input int w, input logic [4:0] c, output bit has, output logic [7:0] ch);
    has = 1'b0;
    ch = '0;
    if (c == 5'h1F) mfigs[w] = 0;
    else if (c == 5'h1B) mfigs[w] = 1;
    else if (c != 5'h00) begin
      has = 1'b1;
      ch = model_char(c, mfigs[w]);
      if (USOS && c == 5'h04) mfigs[w] = 0;
    end
  endtask

  function automatic vec_t mk(input logic [4:0] c, input bit ok, input bit has,
                              input logic [7:0] ch, input bit figs);
    vec_t v;
    v.code = c; v.stop_ok = ok; v.has = has; v.ch = ch; v.figs = figs;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_ascii_tx"}, tx_m, 1);
    check({tag, "_valid"}, valid_m, 0);
    check({tag, "_code"}, code_m, 0);
    check({tag, "_figs"}, figs_m, 0);
    check({tag, "_frame_err"}, err_m, 0);
    check({tag, "_overflow"}, ovf_m, 0);
    check({tag, "_busy"}, busy_m, 0);
    check({tag, "_ovf_dut_overflow"}, ovf_o, 0);
    check({tag, "_ovf_dut_tx"}, tx_o, 1);
  endtask

  initial begin
    bit has;
    logic [7:0] ch;
    logic [4:0] c;
    bit ok;
    int t, v0, e0;

    tbl.push_back(mk(5'h1B, 1, 0, 8'h00, 1));
    tbl.push_back(mk(5'h01, 1, 1, 8'h33, 1));
    tbl.push_back(mk(5'h1F, 1, 0, 8'h00, 0));
    tbl.push_back(mk(5'h01, 1, 1, 8'h45, 0));
    tbl.push_back(mk(5'h05, 0, 0, 8'h00, 0));
    tbl.push_back(mk(5'h1B, 1, 0, 8'h00, 1));
    tbl.push_back(mk(5'h04, 1, 1, 8'h20, !USOS));
    tbl.push_back(mk(5'h01, 1, 1, USOS ? 8'h45 : 8'h33, !USOS));
    tbl.push_back(mk(5'h1B, 1, 0, 8'h00, 1));
    tbl.push_back(mk(5'h05, 1, 1, 8'h07, 1));
    tbl.push_back(mk(5'h0B, 1, 1, 8'h27, 1));
    tbl.push_back(mk(5'h1F, 1, 0, 8'h00, 0));
    tbl.push_back(mk(5'h00, 1, 0, 8'h00, 0));
    tbl.push_back(mk(5'h02, 1, 1, 8'h0A, 0));
    tbl.push_back(mk(5'h1E, 1, 1, 8'h56, 0));

    #1 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First character: 3-cycle latency from baudot_valid to the start bit.
    do_frame(0, 5'h03, 1, 4, 1, 8'h41, 0);
    check("latency_valid_to_start", last_start[0] - last_vcyc[0], 3);
    repeat (40) @(negedge clk);

    foreach (tbl[i])
      do_frame(0, tbl[i].code, tbl[i].stop_ok, 6, tbl[i].has, tbl[i].ch, tbl[i].figs);
    mfigs[0] = 0;

    // Short low glitch: nothing at all happens.
    v0 = vcnt[0]; e0 = ecnt[0];
    rx_m = 1'b0;
    repeat (5) @(negedge clk);
    rx_m = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_valid", vcnt[0] - v0, 0);
    check("glitch_no_err", ecnt[0] - e0, 0);
    check("glitch_no_busy", busy_m, 0);

    // Randomised traffic against the shift-state model.
    for (int n = 0; n < 40; n++) begin
      c = 5'($urandom_range(0, 31));
      ok = ($urandom_range(0, 9) != 0);
      if (ok) begin
        model_step(0, c, has, ch);
        do_frame(0, c, 1, $urandom_range(4, 40), has, ch, mfigs[0][0]);
      end else begin
        do_frame(0, c, 0, $urandom_range(4, 40), 0, 8'h00, mfigs[0][0]);
      end
    end
    t = 0;
    while ((q0.size() != 0 || busy_m) && t < 2000) begin @(negedge clk); t++; end
    check("main_drain_in_time", t < 2000, 1);

    // Reset mid-frame with the line held low, after leaving figures mode set.
    do_frame(0, 5'h1B, 1, 6, 0, 8'h00, 1);
    v0 = vcnt[0]; e0 = ecnt[0];
    rx_m = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midframe_reset");
    repeat (3) @(negedge clk);
    rx_m = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    mfigs[0] = 0; last_code[0] = 5'h00;
    repeat (10) @(negedge clk);
    check("abandoned_frame_no_err", ecnt[0] - e0, 0);
    check("abandoned_frame_no_valid", vcnt[0] - v0, 0);
    do_frame(0, 5'h03, 1, 4, 1, 8'h41, 0);
    repeat (50) @(negedge clk);

    // Overflow: slow transmitter, six letters; the sixth is dropped.
    do_frame(1, 5'h03, 1, 4, 1, 8'h41, 0);
    do_frame(1, 5'h01, 1, 4, 1, 8'h45, 0);
    do_frame(1, 5'h05, 1, 4, 1, 8'h53, 0);
    do_frame(1, 5'h06, 1, 4, 1, 8'h49, 0);
    do_frame(1, 5'h07, 1, 4, 1, 8'h55, 0);
    check("overflow_clear_before_6th", ovf_o, 0);
    do_frame(1, 5'h0A, 1, 4, 0, 8'h00, 0);
    check("overflow_set_on_6th", ovf_o, 1);
    t = 0;
    while ((q1.size() != 0 || busy_o) && t < 20000) begin @(negedge clk); t++; end
    check("ovf_drain_in_time", t < 20000, 1);
    repeat (ODIV * 12) @(negedge clk);
    check("overflow_sticky", ovf_o, 1);
    check("ovf_dut_idle", busy_o, 0);

    #2 rst_n = 1'b0;
    #1 check("overflow_cleared_by_reset", ovf_o, 0);
    check("final_reset_tx_high", tx_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("main_queue_empty", q0.size(), 0);
    check("ovf_queue_empty", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
